// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: shared definitions for the RV32IM MEM stage.
//   - funct3 encodings for loads and stores
//   - MEM-stage FSM state type
//   - EX/MEM and MEM/WB pipeline register layouts
//   - misalignment predicate shared by the stage and the aligner
package rv32_mem_pkg;

    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;
    localparam logic [2:0] Funct3Sb  = 3'b000;
    localparam logic [2:0] Funct3Sh  = 3'b001;
    localparam logic [2:0] Funct3Sw  = 3'b010;

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } mem_state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mux3_select;
        logic [2:0]  funct3;
        logic [31:0] alud;
        logic [31:0] addr;
        logic [31:0] data2;
    } ex_mem_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic [31:0] data;
        logic        misalign_fault;
    } mem_wb_t;

    // Loads decode size from funct3[1:0] (LBU/LHU share LB/LH sizes); stores
    // only treat SB/SH as sub-word, everything else is a word.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo,
                                           input logic       is_store);
        logic is_byte;
        logic is_half;
        is_byte = is_store ? (funct3 == Funct3Sb) : (funct3[1:0] == 2'b00);
        is_half = is_store ? (funct3 == Funct3Sh) : (funct3[1:0] == 2'b01);
        if (is_byte) begin
            return 1'b0;
        end else if (is_half) begin
            return addr_lo[0];
        end else begin
            return addr_lo != 2'b00;
        end
    endfunction

endpackage

// File: rtl/load_store_align.sv
// load_store_align: combinational byte-lane steering for the MEM stage.
//   funct3     in  3  : access size / sign
//   addr_lo    in  2  : low address bits of the access
//   is_store   in  1  : access is a store (selects store size decode)
//   data2      in 32  : raw store data
//   rdata      in 32  : raw word read from memory
//   wdata      out 32 : lane-replicated store data
//   wstrb      out 4  : byte write strobes
//   load_data  out 32 : extracted and extended load value
//   misaligned out 1  : access crosses its natural alignment
module load_store_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic [31:0] data2,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        wdata = data2;
        wstrb = 4'b1111;
        case (funct3)
            Funct3Sb: begin
                wdata = {4{data2[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            Funct3Sh: begin
                wdata = {2{data2[15:0]}};
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            Funct3Lb:  load_data = {{24{lane_b[7]}}, lane_b};
            Funct3Lbu: load_data = {24'b0, lane_b};
            Funct3Lh:  load_data = {{16{lane_h[15]}}, lane_h};
            Funct3Lhu: load_data = {16'b0, lane_h};
            default:   load_data = rdata;
        endcase
    end

    assign misaligned = is_misaligned(funct3, addr_lo, is_store);

endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: RV32IM MEM stage. Owns the EX/MEM and MEM/WB registers,
// runs a ready-handshake to data memory and stalls upstream while waiting.
//   clk, reset (sync, active-high)
//   ex_valid, ALUD, ALU_result, data2, funct3, rd, regwrite_enable,
//   memory_read_enable, memory_write_enable, mux3_select : EX stage outputs
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb, mem_ready/mem_rdata : memory
//   mem_stall : freeze IF/ID/EX
//   EX_MEM_*, MEM_WB_* : forwarding / writeback sources
//   misalign_fault : registered with MEM/WB
// Option: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of
// silently aligning them down.
module memory_access_stage
    import rv32_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ALUD,
    input  logic [31:0] ALU_result,
    input  logic [31:0] data2,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        regwrite_enable,
    input  logic        memory_read_enable,
    input  logic        memory_write_enable,
    input  logic        mux3_select,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic [4:0]  EX_MEM_rd,
    output logic        EX_MEM_regWrite,
    output logic        EX_MEM_memRead,
    output logic [31:0] EX_MEM_data,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_regWrite,
    output logic        MEM_WB_memRead,
    output logic [31:0] MEM_WB_data,
    output logic        misalign_fault
);

    mem_state_e state_q, state_d;
    ex_mem_t    ex_mem_q, ex_mem_d;
    mem_wb_t    mem_wb_q, mem_wb_d;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] load_data;
    logic        wb_misaligned;
    logic        capture_mem_op;
    logic        ex_misaligned;

    load_store_align u_align (
        .funct3     (ex_mem_q.funct3),
        .addr_lo    (ex_mem_q.addr[1:0]),
        .is_store   (ex_mem_q.mem_write),
        .data2      (ex_mem_q.data2),
        .rdata      (mem_rdata),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .load_data  (load_data),
        .misaligned (wb_misaligned)
    );

    assign capture_mem_op = ex_valid && (memory_read_enable || memory_write_enable);

`ifdef MEM_MISALIGN_TRAP_EN
    assign ex_misaligned = is_misaligned(funct3, ALU_result[1:0], memory_write_enable);
`else
    assign ex_misaligned = 1'b0;
    logic unused_misaligned;
    assign unused_misaligned = wb_misaligned;
`endif

    assign mem_stall = (state_q == StAccess) && !mem_ready;

    always_comb begin
        ex_mem_d = ex_mem_q;
        state_d  = state_q;
        mem_wb_d = '0;
        if (!mem_stall) begin
            ex_mem_d = '0;
            if (ex_valid) begin
                ex_mem_d.rd          = rd;
                ex_mem_d.reg_write   = regwrite_enable;
                ex_mem_d.mem_read    = memory_read_enable;
                ex_mem_d.mem_write   = memory_write_enable;
                ex_mem_d.mux3_select = mux3_select;
                ex_mem_d.funct3      = funct3;
                ex_mem_d.alud        = ALUD;
                ex_mem_d.addr        = ALU_result;
                ex_mem_d.data2       = data2;
            end
            // A trapped misaligned op is captured but never requests memory.
            state_d = (capture_mem_op && !ex_misaligned) ? StAccess : StIdle;

            mem_wb_d.rd        = ex_mem_q.rd;
            mem_wb_d.reg_write = ex_mem_q.reg_write;
            mem_wb_d.mem_read  = ex_mem_q.mem_read;
            mem_wb_d.data      = ex_mem_q.mux3_select ? load_data : ex_mem_q.alud;
`ifdef MEM_MISALIGN_TRAP_EN
            if ((ex_mem_q.mem_read || ex_mem_q.mem_write) && wb_misaligned) begin
                mem_wb_d.reg_write      = 1'b0;
                mem_wb_d.mem_read       = 1'b0;
                mem_wb_d.misalign_fault = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            state_q  <= state_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign mem_req   = (state_q == StAccess);
    assign mem_we    = ex_mem_q.mem_write;
    assign mem_addr  = {ex_mem_q.addr[31:2], 2'b00};
    assign mem_wdata = wdata;
    assign mem_wstrb = ex_mem_q.mem_write ? wstrb : 4'b0000;

    assign EX_MEM_rd       = ex_mem_q.rd;
    assign EX_MEM_regWrite = ex_mem_q.reg_write;
    assign EX_MEM_memRead  = ex_mem_q.mem_read;
    assign EX_MEM_data     = ex_mem_q.alud;

    assign MEM_WB_rd       = mem_wb_q.rd;
    assign MEM_WB_regWrite = mem_wb_q.reg_write;
    assign MEM_WB_memRead  = mem_wb_q.mem_read;
    assign MEM_WB_data     = mem_wb_q.data;
    assign misalign_fault  = mem_wb_q.misalign_fault;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed self-checking bench for memory_access_stage.
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ALUD, ALU_result, data2;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        regwrite_enable, memory_read_enable, memory_write_enable, mux3_select;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic [4:0]  EX_MEM_rd, MEM_WB_rd;
    logic        EX_MEM_regWrite, EX_MEM_memRead, MEM_WB_regWrite, MEM_WB_memRead;
    logic [31:0] EX_MEM_data, MEM_WB_data;
    logic        misalign_fault;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    memory_access_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .ex_valid            (ex_valid),
        .ALUD                (ALUD),
        .ALU_result          (ALU_result),
        .data2               (data2),
        .funct3              (funct3),
        .rd                  (rd),
        .regwrite_enable     (regwrite_enable),
        .memory_read_enable  (memory_read_enable),
        .memory_write_enable (memory_write_enable),
        .mux3_select         (mux3_select),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_wstrb           (mem_wstrb),
        .mem_ready           (mem_ready),
        .mem_rdata           (mem_rdata),
        .mem_stall           (mem_stall),
        .EX_MEM_rd           (EX_MEM_rd),
        .EX_MEM_regWrite     (EX_MEM_regWrite),
        .EX_MEM_memRead      (EX_MEM_memRead),
        .EX_MEM_data         (EX_MEM_data),
        .MEM_WB_rd           (MEM_WB_rd),
        .MEM_WB_regWrite     (MEM_WB_regWrite),
        .MEM_WB_memRead      (MEM_WB_memRead),
        .MEM_WB_data         (MEM_WB_data),
        .misalign_fault      (misalign_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] alud,
                          input logic [31:0] d2, input logic [4:0] rdi, input logic rw,
                          input logic mr, input logic mw, input logic m3);
        ex_valid            = 1'b1;
        funct3              = f3;
        ALU_result          = addr;
        ALUD                = alud;
        data2               = d2;
        rd                  = rdi;
        regwrite_enable     = rw;
        memory_read_enable  = mr;
        memory_write_enable = mw;
        mux3_select         = m3;
    endtask

    task automatic bubble();
        ex_valid            = 1'b0;
        funct3              = 3'b0;
        ALU_result          = 32'h0;
        ALUD                = 32'h0;
        data2               = 32'h0;
        rd                  = 5'd0;
        regwrite_enable     = 1'b0;
        memory_read_enable  = 1'b0;
        memory_write_enable = 1'b0;
        mux3_select         = 1'b0;
    endtask

    initial begin
        bubble();
        reset     = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_req", mem_req, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_wstrb", mem_wstrb, 0);
        check("rst_exrd", EX_MEM_rd, 0);
        check("rst_wbdata", MEM_WB_data, 0);
        check("rst_fault", misalign_fault, 0);

        // SB at 0x103, zero-wait.
        set_ex(3'b000, 32'h103, 32'h0, 32'hA5, 5'd0, 0, 0, 1, 0);
        mem_ready = 1'b1;
        tick();
        bubble();
        #1;
        check("sb_req", mem_req, 1);
        check("sb_we", mem_we, 1);
        check("sb_addr", mem_addr, 32'h100);
        check("sb_wstrb", mem_wstrb, 4'b1000);
        check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        check("sb_stall", mem_stall, 0);
        tick();
        check("sb_req_done", mem_req, 0);

        // SH at 0x102.
        set_ex(3'b001, 32'h102, 32'h0, 32'h1234ABCD, 5'd0, 0, 0, 1, 0);
        tick();
        bubble();
        #1;
        check("sh_wstrb", mem_wstrb, 4'b1100);
        check("sh_wdata", mem_wdata, 32'hABCDABCD);
        tick();

        // LB then LBU back-to-back at 0x102.
        mem_rdata = 32'h12F03456;
        set_ex(3'b000, 32'h102, 32'h0, 32'h0, 5'd7, 1, 1, 0, 1);
        tick();
        set_ex(3'b100, 32'h102, 32'h0, 32'h0, 5'd8, 1, 1, 0, 1);
        #1;
        check("lb_req", mem_req, 1);
        check("lb_exrd", EX_MEM_rd, 7);
        check("lb_exmr", EX_MEM_memRead, 1);
        tick();
        bubble();
        #1;
        check("lb_data", MEM_WB_data, 32'hFFFFFFF0);
        check("lb_wbrd", MEM_WB_rd, 7);
        check("lb_wbmr", MEM_WB_memRead, 1);
        check("b2b_req", mem_req, 1);
        tick();
        check("lbu_data", MEM_WB_data, 32'h000000F0);
        check("lbu_wbrd", MEM_WB_rd, 8);
        check("lbu_req_done", mem_req, 0);

        // LH sign extension from upper half.
        mem_rdata = 32'h8001_0000;
        set_ex(3'b001, 32'h102, 32'h0, 32'h0, 5'd6, 1, 1, 0, 1);
        tick();
        bubble();
        tick();
        check("lh_data", MEM_WB_data, 32'hFFFF8001);

        // LW with 3 wait states.
        mem_ready = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        set_ex(3'b010, 32'h200, 32'h0, 32'h0, 5'd9, 1, 1, 0, 1);
        tick();
        bubble();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ws_stall", mem_stall, 1);
            check("ws_exrd", EX_MEM_rd, 9);
            tick();
            check("ws_bubble", MEM_WB_regWrite, 0);
        end
        mem_ready = 1'b1;
        #1;
        check("ws_stall_end", mem_stall, 0);
        check("ws_req", mem_req, 1);
        tick();
        check("ws_data", MEM_WB_data, 32'hDEADBEEF);
        check("ws_wbrw", MEM_WB_regWrite, 1);
        check("ws_wbrd", MEM_WB_rd, 9);
        mem_ready = 1'b0;
        tick();
        check("ws_once", MEM_WB_regWrite, 0);

        // Non-memory pass-through.
        set_ex(3'b000, 32'h0, 32'h1234, 32'h0, 5'd5, 1, 0, 0, 0);
        tick();
        bubble();
        check("alu_exrd", EX_MEM_rd, 5);
        check("alu_exdata", EX_MEM_data, 32'h1234);
        check("alu_exrw", EX_MEM_regWrite, 1);
        check("alu_req", mem_req, 0);
        tick();
        check("alu_wbdata", MEM_WB_data, 32'h1234);
        check("alu_wbrd", MEM_WB_rd, 5);
        check("alu_wbrw", MEM_WB_regWrite, 1);

        // Reset during the second wait cycle.
        mem_ready = 1'b0;
        mem_rdata = 32'h55AA55AA;
        set_ex(3'b010, 32'h300, 32'h0, 32'h0, 5'd3, 1, 1, 0, 1);
        tick();
        bubble();
        tick();
        check("rma_stall", mem_stall, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rma_req", mem_req, 0);
        check("rma_stall0", mem_stall, 0);
        check("rma_exrd", EX_MEM_rd, 0);
        check("rma_exmr", EX_MEM_memRead, 0);
        check("rma_addr", mem_addr, 0);
        check("rma_wbrw", MEM_WB_regWrite, 0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("rma_late_req", mem_req, 0);
        check("rma_late_data", MEM_WB_data, 0);
        check("rma_late_rw", MEM_WB_regWrite, 0);

        // Misaligned LW at 0x102.
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        set_ex(3'b010, 32'h102, 32'h0, 32'h0, 5'd4, 1, 1, 0, 1);
        tick();
        bubble();
        #1;
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_req", mem_req, 0);
        check("mis_stall", mem_stall, 0);
        tick();
        check("mis_fault", misalign_fault, 1);
        check("mis_rw", MEM_WB_regWrite, 0);
        tick();
        check("mis_fault_end", misalign_fault, 0);
`else
        check("mis_req", mem_req, 1);
        check("mis_addr", mem_addr, 32'h100);
        tick();
        check("mis_data", MEM_WB_data, 32'hCAFEF00D);
        check("mis_rw", MEM_WB_regWrite, 1);
        check("mis_fault", misalign_fault, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline MEM stage for the RV32IM core: owns the EX/MEM pipeline register, drives the data memory through a ready-handshake, aligns stores, extracts and extends loads, and produces the MEM/WB register. It is the producer end of the forwarding interface that the execute stage consumes. It supplies `EX_MEM_*` and `MEM_WB_*` rd, regWrite, memRead and data. It raises `mem_stall` to freeze IF/ID/EX while a data access is outstanding.

## Interface
- No parameters. Data width is fixed at 32 and register index width at 5.
- `clk` in 1: sole clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ex_valid` in 1: EX output holds a real instruction (0 = bubble).
- `ALUD` in 32: writeback value for non-loads (pc4 or ALU result).
- `ALU_result` in 32: effective address for loads and stores.
- `data2` in 32: store data.
- `funct3` in 3: access size and sign.
- `rd` in 5: destination register.
- `regwrite_enable`, `memory_read_enable`, `memory_write_enable`, `mux3_select` in 1 each. `mux3_select` = 1 selects load data for writeback.
- `mem_req` out 1: access request.
- `mem_we` out 1: write request.
- `mem_addr` out 32: word-aligned address.
- `mem_wdata` out 32: store data.
- `mem_wstrb` out 4: byte-lane write strobes.
- `mem_ready` in 1: access completes this cycle.
- `mem_rdata` in 32: read data, valid when `mem_ready` is 1.
- `mem_stall` out 1: hold upstream stages this cycle.
- `EX_MEM_rd` out 5, `EX_MEM_regWrite` out 1, `EX_MEM_memRead` out 1, `EX_MEM_data` out 32: forwarding source from the EX/MEM register.
- `MEM_WB_rd` out 5, `MEM_WB_regWrite` out 1, `MEM_WB_memRead` out 1, `MEM_WB_data` out 32: writeback value and forwarding source.
- `misalign_fault` out 1: registered alongside MEM/WB.

## Operation
- **EX/MEM capture.** EX/MEM loads the EX inputs on every edge where `mem_stall` = 0.
  - A field with `ex_valid` = 0 loads as a bubble: all enables 0.
  - While `mem_stall` = 1, EX/MEM holds its contents.
- **FSM states.** IDLE and ACCESS.
  - IDLE → ACCESS on an edge that captures a valid instruction with a read or write enable.
  - ACCESS → IDLE on an edge where `mem_ready` = 1, unless a new memory op is captured on that same edge, in which case the FSM stays in ACCESS.
- **Request outputs.**
  - `mem_req` = (state == ACCESS).
  - `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` are derived from EX/MEM only, so they stay stable until `mem_ready` is seen.
- **Stall.** `mem_stall` = ACCESS && !`mem_ready`, combinational.
- **Address.** `mem_addr` = {addr[31:2], 2'b00}.
- **Stores.**
  - SB (000): wdata = {4{data2[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - SH (001): wdata = {2{data2[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - SW (010) and all other funct3 values: wdata = data2, wstrb = 4'b1111.
- **Loads.**
  - LB / LBU: byte lane addr[1:0], sign-extended / zero-extended.
  - LH / LHU: half lane addr[1], sign-extended / zero-extended.
  - LW and the remaining funct3 values: full word.
- **MEM/WB update.** MEM/WB updates every edge.
  - While `mem_stall` = 1 it loads a bubble: `MEM_WB_regWrite` = 0, `MEM_WB_memRead` = 0.
  - Otherwise `MEM_WB_data` = `mux3_select` ? load data : ALUD, and the rd and enable fields are copied from EX/MEM.
- **Forwarding data.** `EX_MEM_data` = registered ALUD. This is not valid for loads; the hazard logic stalls those on `EX_MEM_memRead`.
- **Handshake.** `mem_ready` is ignored while `mem_req` = 0.

## Timing
- **Zero-wait memory.** With `mem_ready` = 1 in the first ACCESS cycle there is no stall. Load data appears on `MEM_WB_data` one edge after the EX/MEM capture edge.
- **Wait states.** Each cycle of `mem_ready` = 0 adds one stall cycle and one MEM/WB bubble.
- **Reset.** Reset forces IDLE and clears EX/MEM and MEM/WB. All outputs read 0 the cycle after reset, including `mem_req`, `mem_stall` and `misalign_fault`.
  - Reset during ACCESS abandons the access.
  - A `mem_ready` arriving after reset is ignored.
- **Back-to-back.** Two consecutive memory ops issue `mem_req` continuously, with no idle cycle between them.

## Configuration
- **`MEM_MISALIGN_TRAP_EN` defined.**
  - A misaligned access (half with addr[0] = 1, or word with addr[1:0] ≠ 0) never enters ACCESS and produces no stall.
  - MEM/WB records it as regWrite = 0 with `misalign_fault` = 1 for one cycle.
- **Undefined.**
  - Address bits below the access size are ignored: LH at 0x3 reads the half at 0x2.
  - `misalign_fault` is tied to 0.

## Structure
- Package `rv32_mem_pkg` holds:
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW;
  - the FSM state typedef;
  - the EX/MEM and MEM/WB struct typedefs.
- Sub-module `load_store_align`: combinational wdata/wstrb generation, lane extraction and extension, and misalignment detect.

## Test plan
- **SB store.** SB, addr 0x103, data2 0x000000A5, `mem_ready` = 1 → `mem_req` for 1 cycle, `mem_addr` 0x100, wstrb 4'b1000, wdata 0xA5A5A5A5, no stall.
- **LB sign extension.** LB, addr 0x102, rdata 0x12F03456 → `MEM_WB_data` 0xFFFFFFF0. The same access as LBU → 0x000000F0.
- **Wait states.** LW with `mem_ready` low for 3 cycles → `mem_stall` high for exactly 3 cycles, 3 MEM/WB bubbles, then the load writes back once, with `EX_MEM_rd` held throughout.
- **Non-memory pass-through.** ALU op, rd = 5, ALUD 0x1234 → `EX_MEM_rd` = 5 and `EX_MEM_data` 0x1234 next edge, then `MEM_WB_data` 0x1234 one edge later, with no `mem_req`.
- **Reset mid-access.** Reset asserted in the second wait cycle → next cycle `mem_req` = 0, `mem_stall` = 0 and all registers zero. A subsequent `mem_ready` pulse changes nothing.
- **Misaligned LW.** LW at 0x102 → with `MEM_MISALIGN_TRAP_EN`: no `mem_req` and a one-cycle `misalign_fault`. Without it: `mem_addr` 0x100 and normal writeback.
